// File: rtl/sram_stream_reader.sv
// sram_stream_reader: walks a contiguous SRAM word range and streams the
// words out in address order over valid/ready, hiding the one-cycle read
// latency and downstream stalls behind a 2-entry buffer.
module sram_stream_reader #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          pop_c;
  logic          issue_c;

  // Handshake and read-issue qualifiers; issue only if the word fits after this cycle's pop
  assign pop_c   = valid_q & out_ready;
  assign issue_c = (state_q == S_RUN) && (rem_q != '0) &&
                   (({1'b0, cnt_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop_c}));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pointer, buffer and status logic
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    rem_d      = rem_q;
    inflight_d = issue_c;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rptr_d = start_addr;
          rem_d  = length;
          if (length != '0) begin
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue_c && (rem_q == (AW+1)'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last word leaves the buffer at this edge with nothing left behind it
        if (!inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_c))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue_c) begin
      rptr_d = rptr_q + AW'(1);
      rem_d  = rem_q - (AW+1)'(1);
    end

    // Buffer: head is the output word, tail holds the second entry
    case ({inflight_q, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = sram_rdata;
        end else begin
          tail_d = sram_rdata;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = sram_rdata;
        end else begin
          head_d = tail_q;
          tail_d = sram_rdata;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    valid_d = (cnt_d != 2'd0);
    busy_d  = (state_d != S_IDLE);
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sram_raddr = rptr_q;
  assign out_valid  = valid_q;
  assign out_data   = head_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: an AW=18 instance and an AW=4 instance share
// clock, reset and stimulus; a queue of expected words built from address
// arithmetic is compared against every output handshake.
module tb_sram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        start;
  logic [17:0] start_addr;
  logic [18:0] length;
  logic        out_ready;

  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b, valid_a, valid_b;
  logic [17:0] raddr_a;
  logic [3:0]  raddr_b;
  logic [15:0] rdata_a, rdata_b, data_a, data_b;

  logic        busy, done, out_valid;
  logic [17:0] sram_raddr;
  logic [15:0] out_data;

  int n_checks;
  int n_errors;

  assign start_a    = start & ~sel;
  assign start_b    = start & sel;
  assign busy       = sel ? busy_b  : busy_a;
  assign done       = sel ? done_b  : done_a;
  assign out_valid  = sel ? valid_b : valid_a;
  assign out_data   = sel ? data_b  : data_a;
  assign sram_raddr = sel ? {14'b0, raddr_b} : raddr_a;

  sram_stream_reader #(.AW(18), .DW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_addr(start_addr),
    .length(length), .busy(busy_a), .done(done_a), .sram_raddr(raddr_a),
    .sram_rdata(rdata_a), .out_valid(valid_a), .out_data(data_a),
    .out_ready(out_ready)
  );

  sram_stream_reader #(.AW(4), .DW(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .start_addr(start_addr[3:0]),
    .length(length[4:0]), .busy(busy_b), .done(done_b), .sram_raddr(raddr_b),
    .sram_rdata(rdata_b), .out_valid(valid_b), .out_data(data_b),
    .out_ready(out_ready)
  );

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // SRAM models: one-cycle registered read
  always @(posedge clk) begin
    rdata_a <= mem_word(raddr_a);
    rdata_b <= mem_word({14'b0, raddr_b});
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer: expected words are start_addr+i modulo the address span
  task automatic run_xfer(input logic sel_i, input int addr, input int len,
                          input bit rand_ready, input bit poke);
    int          span;
    logic [15:0] expq[$];
    int          k;
    int          accepted;
    bit          stalled;
    logic [15:0] held;
    span = sel_i ? 16 : (1 << 18);
    for (int i = 0; i < len; i++) expq.push_back(mem_word(18'((addr + i) % span)));
    sel        = sel_i;
    start      = 1'b1;
    start_addr = 18'(addr);
    length     = 19'(len);
    out_ready  = 1'b1;
    tick();
    start = 1'b0;
    if (len == 0) begin
      check("zlen_done", 32'(done), 32'd1);
      check("zlen_busy", 32'(busy), 32'd0);
      check("zlen_valid", 32'(out_valid), 32'd0);
      tick();
      check("zlen_done2", 32'(done), 32'd0);
      check("zlen_busy2", 32'(busy), 32'd0);
      check("zlen_valid2", 32'(out_valid), 32'd0);
      return;
    end
    check("busy_start", 32'(busy), 32'd1);
    k = 0;
    accepted = 0;
    stalled = 1'b0;
    held = '0;
    while (accepted < len && k < 400) begin
      if (!rand_ready && k < len)
        check("raddr", 32'(sram_raddr), 32'((addr + k) % span));
      if (!rand_ready && k < 2)
        check("early_valid", 32'(out_valid), 32'd0);
      if (poke) begin
        if (k == 3) begin
          start      = 1'b1;
          start_addr = 18'(addr + 256);
          length     = 19'd3;
        end else begin
          start = 1'b0;
        end
      end
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held));
      end
      check("no_early_done", 32'(done), 32'd0);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        check("data", 32'(out_data), 32'(expq[accepted]));
        if (!rand_ready) check("accept_cycle", 32'(k), 32'(2 + accepted));
        accepted++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held    = out_data;
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (accepted < len) check("timeout_words", 32'(accepted), 32'(len));
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    check("end_done2", 32'(done), 32'd0);
  endtask

  // Reset asserted in the middle of a transfer
  task automatic reset_mid_xfer();
    sel        = 1'b0;
    start      = 1'b1;
    start_addr = 18'h200;
    length     = 19'd8;
    out_ready  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_raddr", 32'(sram_raddr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      tick();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    sel        = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_raddr", 32'(sram_raddr), 32'd0);
      check("reset_data", 32'(out_data), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    run_xfer(1'b0, 'h10, 4, 1'b0, 1'b0);
    run_xfer(1'b0, 'h10, 4, 1'b1, 1'b0);
    run_xfer(1'b0, 'h10, 4, 1'b1, 1'b0);
    run_xfer(1'b0, 'h3FFFE, 4, 1'b0, 1'b0);
    run_xfer(1'b0, 'h3FFFE, 4, 1'b1, 1'b0);
    run_xfer(1'b0, 'h123, 0, 1'b0, 1'b0);
    run_xfer(1'b1, 'h3, 0, 1'b0, 1'b0);
    run_xfer(1'b0, 'h40, 8, 1'b0, 1'b1);
    run_xfer(1'b0, 'h40, 8, 1'b1, 1'b1);
    reset_mid_xfer();
    run_xfer(1'b0, 'h55, 5, 1'b0, 1'b0);
    run_xfer(1'b1, 'h5, 16, 1'b0, 1'b0);
    run_xfer(1'b1, 'h9, 16, 1'b1, 1'b0);
    run_xfer(1'b0, 'h7, 1, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++)
      run_xfer(1'b0, int'($urandom_range(0, 'h3FFFF)), int'($urandom_range(1, 12)), 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
